// File: rtl/joybus_pkg.sv
// Shared Joybus transmit definitions: level timing, 4-level bit patterns and
// serializer state encodings.
package joybus_pkg;

  localparam int LEVEL_WIDTH = 2;
  localparam int BIT_WIDTH   = 4 * LEVEL_WIDTH;

  // Patterns are line_low values, MSB = first level on the wire.
  localparam logic [3:0] PAT_ZERO         = 4'b1110;
  localparam logic [3:0] PAT_ONE          = 4'b1000;
  localparam logic [3:0] PAT_CTRL_STOP    = 4'b1100;
  localparam logic [3:0] PAT_CONSOLE_STOP = 4'b1000;

  localparam logic [2:0] LEVELS_BIT  = 3'd4;
  localparam logic [2:0] LEVELS_STOP = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_TURNAROUND = 2'd1,
    ST_SEND_BIT   = 2'd2,
    ST_SEND_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [3:0] bit_pattern(input logic b);
    return b ? PAT_ONE : PAT_ZERO;
  endfunction

endpackage

// File: rtl/joybus_tx_serializer_level_player.sv
// Plays a 4-level line_low pattern, LEVEL_WIDTH cycles per level, for either
// 3 or 4 levels. o_last marks the final cycle of the final level so the
// caller can chain the next pattern with no gap.
module joybus_level_player
  import joybus_pkg::*;
(
  input  logic       sample_clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_clear,
  input  logic [3:0] i_pattern,
  input  logic [2:0] i_levels,
  output logic       o_line_low,
  output logic       o_last
);

  localparam int TW = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;

  logic          r_active;
  logic [3:0]    r_pattern;
  logic [2:0]    r_levels;
  logic [2:0]    r_level;
  logic [TW-1:0] r_timer;
  logic          r_line_low;
  logic          w_level_end;

  assign w_level_end = r_active && (r_timer == TW'(LEVEL_WIDTH - 1));
  assign o_last      = w_level_end && (r_level == (r_levels - 3'd1));
  assign o_line_low  = r_line_low;

  // Level sequencer; the pattern register shifts left so its MSB is always
  // the current level, and line_low is registered for a glitch-free pin.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active   <= 1'b0;
      r_pattern  <= 4'b0;
      r_levels   <= 3'd0;
      r_level    <= 3'd0;
      r_timer    <= '0;
      r_line_low <= 1'b0;
    end else if (i_clear) begin
      r_active   <= 1'b0;
      r_level    <= 3'd0;
      r_timer    <= '0;
      r_line_low <= 1'b0;
    end else if (i_start) begin
      r_active   <= 1'b1;
      r_pattern  <= i_pattern;
      r_levels   <= i_levels;
      r_level    <= 3'd0;
      r_timer    <= '0;
      r_line_low <= i_pattern[3];
    end else if (o_last) begin
      r_active   <= 1'b0;
      r_timer    <= '0;
      r_line_low <= 1'b0;
    end else if (w_level_end) begin
      r_timer    <= '0;
      r_level    <= r_level + 3'd1;
      r_pattern  <= {r_pattern[2:0], 1'b0};
      r_line_low <= r_pattern[2];
    end else if (r_active) begin
      r_timer <= r_timer + TW'(1);
    end
  end

endmodule

// File: rtl/joybus_tx_serializer.sv
// Joybus controller-side transmitter: latches a right-aligned response word,
// waits the turnaround, sends the bits MSB-first as 4-level symbols and ends
// with a controller STOP. Only drives pull-low / release.
module joybus_tx_serializer
  import joybus_pkg::*;
#(
  parameter int MAX_BITS          = 32,
  parameter int TURNAROUND_CYCLES = 4
) (
  input  logic                sample_clk,
  input  logic                reset_n,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [5:0]          tx_len,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic                tx_abort,
  output logic                line_low,
  output logic                tx_done
);

  localparam int TA_W = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;

  tx_state_t           r_state;
  tx_state_t           w_state_next;
  logic [MAX_BITS-1:0] r_shift;
  logic [MAX_BITS-1:0] w_aligned;
  logic [5:0]          r_bits_left;
  logic [TA_W-1:0]     r_ta_cnt;
  logic                r_tx_done;
  logic                w_len_ok;
  logic                w_accept;
  logic                w_abort;
  logic                w_ta_end;
  logic                w_last;
  logic                w_start;
  logic [3:0]          w_pattern;
  logic [2:0]          w_levels;

  // Left-align the payload so the first bit to send is always the MSB.
  assign w_aligned = tx_data << (6'(MAX_BITS) - tx_len);
  assign w_len_ok  = (tx_len != 6'd0) && ({26'd0, tx_len} <= 32'(MAX_BITS));
  assign w_accept  = (r_state == ST_IDLE) && tx_valid && w_len_ok;
  assign w_abort   = (r_state != ST_IDLE) && tx_abort;
  assign w_ta_end  = (r_state == ST_TURNAROUND) &&
                     (r_ta_cnt == TA_W'(TURNAROUND_CYCLES - 1));
  assign tx_done   = r_tx_done;

  // State register.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; abort wins in every busy state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)
        w_state_next = (TURNAROUND_CYCLES == 0) ? ST_SEND_BIT : ST_TURNAROUND;
      ST_TURNAROUND:
        if (w_abort)       w_state_next = ST_IDLE;
        else if (w_ta_end) w_state_next = ST_SEND_BIT;
      ST_SEND_BIT:
        if (w_abort)                              w_state_next = ST_IDLE;
        else if (w_last && r_bits_left == 6'd1)   w_state_next = ST_SEND_STOP;
      ST_SEND_STOP:
        if (w_abort)     w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs: ready in IDLE, and the pattern to load into the player on the
  // edge that begins the next symbol (first bit, following bit, or STOP).
  always_comb begin
    tx_ready  = (r_state == ST_IDLE);
    w_start   = 1'b0;
    w_pattern = PAT_ZERO;
    w_levels  = LEVELS_BIT;
    case (r_state)
      ST_IDLE: if (w_accept && TURNAROUND_CYCLES == 0) begin
        w_start   = 1'b1;
        w_pattern = bit_pattern(w_aligned[MAX_BITS-1]);
      end
      ST_TURNAROUND: if (w_ta_end) begin
        w_start   = 1'b1;
        w_pattern = bit_pattern(r_shift[MAX_BITS-1]);
      end
      ST_SEND_BIT: if (w_last) begin
        w_start = 1'b1;
        if (r_bits_left == 6'd1) begin
          w_pattern = PAT_CTRL_STOP;
          w_levels  = LEVELS_STOP;
        end else begin
          w_pattern = bit_pattern(r_shift[MAX_BITS-2]);
        end
      end
      default: ;
    endcase
  end

  // Payload shift register, bit counter, turnaround timer and done pulse.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_bits_left <= 6'd0;
      r_ta_cnt    <= '0;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_done <= (r_state == ST_SEND_STOP) && w_last && !tx_abort;
      if (w_accept) begin
        r_shift     <= w_aligned;
        r_bits_left <= tx_len;
        r_ta_cnt    <= '0;
      end else if (r_state == ST_TURNAROUND) begin
        r_ta_cnt <= r_ta_cnt + TA_W'(1);
      end else if (r_state == ST_SEND_BIT && w_last) begin
        r_shift     <= r_shift << 1;
        r_bits_left <= r_bits_left - 6'd1;
      end
    end
  end

  joybus_level_player u_player (
    .sample_clk (sample_clk),
    .reset_n    (reset_n),
    .i_start    (w_start),
    .i_clear    (w_abort),
    .i_pattern  (w_pattern),
    .i_levels   (w_levels),
    .o_line_low (line_low),
    .o_last     (w_last)
  );

endmodule

// File: doc/joybus_tx_serializer.md
Name: joybus_tx_serializer

Overview:
Downstream transmit stage of the fake N64 controller. It accepts a right-aligned response word (info 0x050000, status 0x00000000, and so on) plus a bit count from the command/response FSM. It waits a console-to-controller turnaround, then plays the bits MSB-first onto the open-drain Joybus line using 4-level Joybus encoding, ending with a controller STOP bit. It drives only "pull low / release"; the board pull-up supplies HIGH.

Parameters:
LEVEL_WIDTH, 2, sample_clk cycles per level; BIT_WIDTH = 4*LEVEL_WIDTH
MAX_BITS, 32, maximum payload bits per transfer
TURNAROUND_CYCLES, 4, released-line cycles between accept and first bit; 0 is legal

Ports:
sample_clk  input  1  sole clock
reset_n  input  1  asynchronous, active-low reset
tx_data  input  MAX_BITS  payload, right-aligned; bit tx_len-1 is sent first
tx_len  input  6  payload bit count, 1..MAX_BITS
tx_valid  input  1  request; accepted when tx_valid & tx_ready
tx_ready  output  1  high only in IDLE
tx_abort  input  1  synchronous cancel
line_low  output  1  1 = pull Joybus line low; 0 = release (HIGH/Z)
tx_done  output  1  one-cycle pulse on normal completion

Behaviour:
- Interface: one clock, sample_clk; reset_n is asynchronous and active-low.
- Reset values: state IDLE, line_low=0, tx_ready=1, tx_done=0, counters 0. Asserting reset mid-frame releases the line immediately (asynchronously).
- Accept: a request is accepted on an edge in IDLE with tx_valid=1 and 1<=tx_len<=MAX_BITS.
  - tx_data and tx_len are latched into a shift register and bit counter.
  - tx_ready drops the next cycle.
  - tx_len=0 or tx_len>MAX_BITS is ignored: no state change, tx_ready stays high.
- States: IDLE -> TURNAROUND -> SEND_BIT -> SEND_STOP -> IDLE.
- TURNAROUND: line_low=0 for exactly TURNAROUND_CYCLES cycles. With TURNAROUND_CYCLES=0, SEND_BIT begins the cycle after accept.
- SEND_BIT: each bit lasts BIT_WIDTH cycles, four levels of LEVEL_WIDTH cycles each. The line_low pattern per level is:
  - logical 0 = 1,1,1,0 (L,L,L,H)
  - logical 1 = 1,0,0,0 (L,H,H,H)
  - After the last level the shift register shifts and the bit counter decrements. When the counter reaches 0, the next state is SEND_STOP.
- SEND_STOP: controller STOP pattern 1,1,0 (L,L,H) over 3*LEVEL_WIDTH cycles. The fourth level (Z) is released-idle and is not timed.
- Completion: tx_done pulses for 1 cycle in the cycle after the final STOP level ends. The same cycle returns to IDLE with tx_ready=1. A new request can be accepted on that edge.
- Frame length from the accept edge to the tx_done cycle is TURNAROUND_CYCLES + tx_len*BIT_WIDTH + 3*LEVEL_WIDTH cycles.
- line_low is registered, so its level is glitch-free.
- tx_abort=1 in any non-IDLE state: next cycle line_low=0, state IDLE, tx_ready=1, no tx_done. tx_abort has no effect in IDLE.
- Simultaneous tx_abort and tx_valid in IDLE: the request is accepted and the abort is ignored.
- Changes to tx_data/tx_len/tx_valid while busy have no effect.

Decomposition:
- Shared package joybus_pkg holds:
  - LEVEL_WIDTH, BIT_WIDTH
  - 4-bit level patterns: PAT_ZERO=4'b1110, PAT_ONE=4'b1000, PAT_CTRL_STOP=4'b1100, PAT_CONSOLE_STOP=4'b1000
  - state encodings
- One natural sub-module, joybus_level_player:
  - Inputs: a 4-bit pattern, a level count (3 or 4) and start.
  - Steps the pattern with a LEVEL_WIDTH timer and outputs line_low and a last-cycle strobe.
  - The serializer FSM feeds it one pattern per bit.

Test Plan:
- Defaults, tx_len=8, tx_data=0x05, tx_valid 1 cycle:
  - line_low=0 for 4 cycles.
  - Bits 0,0,0,0,0,1,0,1 follow, each 6 cycles low + 2 high ("1": 2 low + 6 high).
  - STOP follows: 4 low, 2 high.
  - tx_done arrives exactly 74 cycles after the accept edge.
- Info response, tx_len=24, tx_data=0x050000: tx_done 202 cycles after accept; the sampled bit stream equals 0x050000 MSB-first.
- Status response, tx_len=32, tx_data=0x00000000: 32 identical "0" bits then STOP; tx_ready is low for the whole frame; tx_done at cycle 266.
- Back-to-back: tx_valid held high with a second word 0xFF, len 8. The second frame is accepted on the tx_done cycle with no gap beyond turnaround, and the first frame is not corrupted.
- tx_abort asserted during bit 3: line_low=0 the next cycle, no tx_done, tx_ready=1. tx_len=0 in IDLE: ignored, line stays released.
- reset_n pulsed low mid-bit while line_low=1: line_low drops asynchronously with no clock edge needed; all outputs return to reset values.
